top_ej_2: RTL and testbench
===========================

Name: top_ej_2

Overview:
- Registered 2-operand, 4-function ALU: add, subtract, bitwise AND, bitwise OR on NB_DATA-bit two's-complement operands.
- Used as the top level of exercise 2, driven directly by the stimulus/board environment.
- Inputs are registered, the operation is combinational, and the result is registered.
- Fixed 2-cycle pipeline, with no handshake.

Parameters:
- NB_DATA, default 16: width of both operands, the result, and all internal data registers. Legal values are 2 or greater.

Ports:
- clock, input, 1: system clock. All registers update on the rising edge.
- i_rst_n, input, 1: asynchronous reset, active-low. Clears all registers.
- i_dataA, input, NB_DATA: operand A, two's complement.
- i_dataB, input, NB_DATA: operand B, two's complement.
- i_sel, input, 2: operation select. Sampled together with the operands.
- o_dataC, output, NB_DATA: registered result, two's complement.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - While i_rst_n = 0, the following registers are forced to 0 immediately, independent of clock: the input registers (A_q, B_q, sel_q) and the output register.
  - o_dataC = 0 during reset.
  - On deassertion, the first rising edge with i_rst_n = 1 samples the inputs.
- Stage 1: on each rising edge, A_q <= i_dataA, B_q <= i_dataB, sel_q <= i_sel.
- Stage 2: on each rising edge, o_dataC <= f(A_q, B_q, sel_q), where:
  - sel 00: A_q + B_q
  - sel 01: A_q - B_q
  - sel 10: A_q & B_q (bitwise)
  - sel 11: A_q | B_q (bitwise)
- Latency:
  - An input change present before rising edge k appears on o_dataC after rising edge k+1.
  - Throughput is one operation per cycle. Back-to-back changes of operands and/or select are each reflected in order.
- Arithmetic:
  - Results are truncated to NB_DATA bits (modulo 2^NB_DATA wrap-around).
  - There is no saturation and no overflow/carry output.
  - Signed overflow wraps. Example: 24330 + 23746 gives 0xBBCC, i.e. -17460.
- Subtraction is A_q + ~B_q + 1 truncated, so A - A = 0 for every A, including the most negative value.
- Logic operations are pure bitwise with no sign handling.
- Select is registered alongside the operands. A select change with unchanged operands therefore also takes 2 edges to appear.
- Reset asserted mid-operation:
  - Pipeline contents are discarded.
  - The output goes to 0 asynchronously and stays 0 until 2 edges after release.
- Output is glitch-free: driven only by a flop, never combinationally from inputs.
- No X propagation after reset: every register has a defined reset value.

Test Plan:
- Reset:
  - Drive A = 0x1234, B = 0x4321, sel = 00, clock running, i_rst_n = 0 → o_dataC = 0x0000 throughout.
  - Release reset → o_dataC = 0x5555 after the 2nd rising edge.
  - Reassert reset between edges → o_dataC = 0 immediately, without waiting for a clock edge.
- Negative operands, A = B = -15 (0xFFF1), stepping sel 00, 01, 10, 11 with each held for 5 cycles → o_dataC = 0xFFE2 (-30), then 0x0000, then 0xFFF1, then 0xFFF1. Each value appears exactly 2 edges after its select change.
- Overflow and logic, A = 0x5F0A (24330), B = 0x5CC2 (23746):
  - sel 00 → 0xBBCC (wraps to -17460)
  - sel 01 → 0x0248 (584)
  - sel 10 → 0x5C02
  - sel 11 → 0x5FCA
- Latency/throughput: change (A, B, sel) on every cycle with a random sequence → o_dataC matches a 2-cycle-delayed reference model every cycle.
- Boundaries:
  - 0x7FFF + 0x0001 → 0x8000
  - 0x8000 - 0x0001 → 0x7FFF
  - 0x8000 - 0x8000 → 0x0000
  - 0xFFFF & 0x0000 → 0x0000
  - 0x0000 | 0xFFFF → 0xFFFF
- Parameter: NB_DATA = 8, A = 0x7F, B = 0x02, sel 00 → 0x81. Same A and B with sel 01 → 0x7D.

Source files
------------

// File: rtl/top_ej_2.sv
// Registered two-operand ALU (add, sub, and, or) with a fixed two-edge latency.
// Operands and select are captured together, and the result is taken from a flop.
module top_ej_2 #(
   parameter int NB_DATA = 16
) (
   input  logic                      clock,
   input  logic                      i_rst_n,
   input  logic signed [NB_DATA-1:0] i_dataA,
   input  logic signed [NB_DATA-1:0] i_dataB,
   input  logic        [1:0]         i_sel,
   output logic signed [NB_DATA-1:0] o_dataC
);

   logic signed [NB_DATA-1:0] dataA_p0;
   logic signed [NB_DATA-1:0] dataB_p0;
   logic        [1:0]         sel_p0;
   logic signed [NB_DATA-1:0] result_p1;

   // Results wrap modulo 2^NB_DATA; subtraction is a + ~b + 1 in the same width.
   function automatic logic signed [NB_DATA-1:0] aluOp(
      input logic signed [NB_DATA-1:0] a,
      input logic signed [NB_DATA-1:0] b,
      input logic        [1:0]         sel
   );
      logic signed [NB_DATA-1:0] res;
      case (sel)
         2'b00:   res = a + b;
         2'b01:   res = a - b;
         2'b10:   res = a & b;
         default: res = a | b;
      endcase
      return res;
   endfunction

   // Stage p0: operand and select capture
   always_ff @(posedge clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dataA_p0 <= '0;
         dataB_p0 <= '0;
         sel_p0   <= '0;
      end else begin
         dataA_p0 <= i_dataA;
         dataB_p0 <= i_dataB;
         sel_p0   <= i_sel;
      end
   end

   // Stage p1: registered result
   always_ff @(posedge clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         result_p1 <= '0;
      end else begin
         result_p1 <= aluOp(dataA_p0, dataB_p0, sel_p0);
      end
   end

   assign o_dataC = result_p1;

endmodule

// File: tb/tb_top_ej_2.sv
// Directed bench for top_ej_2: reset, negative operands, overflow, boundaries,
// per-cycle throughput against a delayed reference, and an 8-bit instance.
module tb_top_ej_2;

   logic        clock;
   logic        rstN;
   logic [15:0] dataA;
   logic [15:0] dataB;
   logic [1:0]  sel;
   logic [15:0] dataC;
   logic [7:0]  dataA8;
   logic [7:0]  dataB8;
   logic [1:0]  sel8;
   logic [7:0]  dataC8;

   int checks = 0;
   int errors = 0;

   top_ej_2 #(.NB_DATA(16)) dut (
      .clock   (clock),
      .i_rst_n (rstN),
      .i_dataA (dataA),
      .i_dataB (dataB),
      .i_sel   (sel),
      .o_dataC (dataC)
   );

   top_ej_2 #(.NB_DATA(8)) dut8 (
      .clock   (clock),
      .i_rst_n (rstN),
      .i_dataA (dataA8),
      .i_dataB (dataB8),
      .i_sel   (sel8),
      .o_dataC (dataC8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference built from a 17-bit sum, independent of the DUT's expression.
   function automatic logic [15:0] refAlu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] s);
      logic [16:0] t;
      case (s)
         2'd0:    t = {1'b0, a} + {1'b0, b};
         2'd1:    t = {1'b0, a} + {1'b0, ~b} + 17'd1;
         2'd2:    t = {1'b0, a & b};
         default: t = {1'b0, a | b};
      endcase
      return t[15:0];
   endfunction

   task automatic test_reset();
      rstN  = 1'b0;
      dataA = 16'h1234;
      dataB = 16'h4321;
      sel   = 2'b00;
      dataA8 = 8'h00;
      dataB8 = 8'h00;
      sel8   = 2'b00;
      #2;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dataC !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %h expected 0000", i, dataC);
         end
      end
      rstN = 1'b1;
      tick();
      checks++;
      if (dataC !== 16'h0000) begin
         errors++;
         $display("FAIL reset_release_edge1: got %h expected 0000", dataC);
      end
      tick();
      checks++;
      if (dataC !== 16'h5555) begin
         errors++;
         $display("FAIL reset_release_edge2: got %h expected 5555", dataC);
      end
      #2;
      rstN = 1'b0;
      #1;
      checks++;
      if (dataC !== 16'h0000) begin
         errors++;
         $display("FAIL reset_async: got %h expected 0000", dataC);
      end
      rstN = 1'b1;
      tick();
      checks++;
      if (dataC !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rerelease_edge1: got %h expected 0000", dataC);
      end
      tick();
      checks++;
      if (dataC !== 16'h5555) begin
         errors++;
         $display("FAIL reset_rerelease_edge2: got %h expected 5555", dataC);
      end
   endtask

   task automatic test_negative();
      logic [15:0] expVals [4];
      logic [15:0] prev;
      expVals[0] = 16'hFFE2;
      expVals[1] = 16'h0000;
      expVals[2] = 16'hFFF1;
      expVals[3] = 16'hFFF1;
      prev  = 16'h5555;
      dataA = 16'hFFF1;
      dataB = 16'hFFF1;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         checks++;
         if (dataC !== prev) begin
            errors++;
            $display("FAIL neg_latency sel=%0d: got %h expected %h", s, dataC, prev);
         end
         for (int c = 1; c < 5; c++) begin
            tick();
            checks++;
            if (dataC !== expVals[s]) begin
               errors++;
               $display("FAIL neg sel=%0d cyc=%0d: got %h expected %h", s, c, dataC, expVals[s]);
            end
         end
         prev = expVals[s];
      end
   endtask

   task automatic test_overflow_logic();
      logic [15:0] expVals [4];
      expVals[0] = 16'hBBCC;
      expVals[1] = 16'h0248;
      expVals[2] = 16'h5C02;
      expVals[3] = 16'h5FCA;
      dataA = 16'h5F0A;
      dataB = 16'h5CC2;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         tick();
         checks++;
         if (dataC !== expVals[s]) begin
            errors++;
            $display("FAIL ovf_logic sel=%0d: got %h expected %h", s, dataC, expVals[s]);
         end
      end
   endtask

   task automatic test_boundaries();
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic [1:0]  vs [5];
      logic [15:0] ve [5];
      va[0] = 16'h7FFF; vb[0] = 16'h0001; vs[0] = 2'd0; ve[0] = 16'h8000;
      va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 2'd1; ve[1] = 16'h7FFF;
      va[2] = 16'h8000; vb[2] = 16'h8000; vs[2] = 2'd1; ve[2] = 16'h0000;
      va[3] = 16'hFFFF; vb[3] = 16'h0000; vs[3] = 2'd2; ve[3] = 16'h0000;
      va[4] = 16'h0000; vb[4] = 16'hFFFF; vs[4] = 2'd3; ve[4] = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         dataA = va[i];
         dataB = vb[i];
         sel   = vs[i];
         tick();
         tick();
         checks++;
         if (dataC !== ve[i]) begin
            errors++;
            $display("FAIL boundary[%0d] %h op%0d %h: got %h expected %h",
                     i, va[i], vs[i], vb[i], dataC, ve[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] expQ [$];
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  s;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         s = 2'($urandom_range(0, 3));
         dataA = a;
         dataB = b;
         sel   = s;
         expQ.push_back(refAlu(a, b, s));
         tick();
         if (i >= 1) begin
            checks++;
            if (dataC !== expQ[0]) begin
               errors++;
               $display("FAIL b2b[%0d]: got %h expected %h", i - 1, dataC, expQ[0]);
            end
            void'(expQ.pop_front());
         end
      end
      tick();
      checks++;
      if (dataC !== expQ[0]) begin
         errors++;
         $display("FAIL b2b_last: got %h expected %h", dataC, expQ[0]);
      end
   endtask

   task automatic test_param8();
      dataA8 = 8'h7F;
      dataB8 = 8'h02;
      sel8   = 2'b00;
      tick();
      tick();
      checks++;
      if (dataC8 !== 8'h81) begin
         errors++;
         $display("FAIL nb8_add: got %h expected 81", dataC8);
      end
      sel8 = 2'b01;
      tick();
      tick();
      checks++;
      if (dataC8 !== 8'h7D) begin
         errors++;
         $display("FAIL nb8_sub: got %h expected 7d", dataC8);
      end
   endtask

   initial begin
      test_reset();
      test_negative();
      test_overflow_logic();
      test_boundaries();
      test_back_to_back();
      test_param8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
